// File: rtl/pmt_scan_pkg.sv
// Shared definitions for the PMT scan arbiter: state encoding, requester
// indices, command/select bit positions and small selection helpers.
package pmt_scan_pkg;

    localparam int UNIT_MS_DEF = 100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] REQ_REAL = 2'd0;
    localparam logic [1:0] REQ_TIME = 2'd1;
    localparam logic [1:0] REQ_CAL  = 2'd2;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_TEST_BIT  = 1;
    localparam int SEL_ACC_BIT   = 3;

    // Fixed priority: real scan beats timed test beats calibration.
    function automatic logic [1:0] prio_pick(input logic [2:0] elig);
        if (elig[REQ_REAL])
            return REQ_REAL;
        else if (elig[REQ_TIME])
            return REQ_TIME;
        else
            return REQ_CAL;
    endfunction

    function automatic logic [3:0] sel_strobe(input logic acc, input logic [2:0] sel);
        logic [3:0] s;
        s[2:0]        = sel;
        s[SEL_ACC_BIT] = acc & (|sel);
        return s;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick source: down-counter reloaded from UNIT_MS-1, one-cycle
// tick at terminal count while enabled, held at reload value while disabled.
module ms_tick_gen #(
    parameter int UNIT_MS = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(UNIT_MS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_cnt <= '0;
        else if (!en_i || r_cnt == '0)
            r_cnt <= RELOAD;
        else
            r_cnt <= r_cnt - 1'b1;
    end

    assign tick_o = en_i && (r_cnt == '0);

endmodule

// File: rtl/pmt_scan_arb.sv
// Non-preemptive fixed-priority arbiter handing the PMT scan command path to
// one of three requesters, with ms ownership timeout and post-release guard gap.
module pmt_scan_arb
    import pmt_scan_pkg::*;
#(
    parameter real TCQ     = 0.1,
    parameter int  UNIT_MS = UNIT_MS_DEF,
    parameter int  GAP_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        acc_job_control_i,
    input  logic [2:0]  req_i,
    input  logic [8:0]  req_sel_i,
    input  logic [11:0] req_cmd_i,
    input  logic [31:0] hold_ms_i,
    output logic [2:0]  grant_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [3:0]  pmt_scan_cmd_sel_o,
    output logic [3:0]  pmt_scan_cmd_o
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    // Logic is zero-delay; TCQ only matters to behavioural models sharing this parameter list.
    if (TCQ < 0.0) begin : g_tcq_negative
    end

    // IDLE: sample requests | OWN: owner drives cmd, ms timer runs | GAP: guard delay
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_lockout;
    logic [3:0]         r_sel_lat;
    logic [31:0]        r_hold;
    logic [31:0]        r_ms_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [2:0]         w_elig;
    logic [1:0]         w_pick;
    logic [2:0]         w_pick_sel;
    logic [3:0]         w_pick_cmd;
    logic               w_own_req;
    logic               w_own_st;
    logic               w_timeout_hit;
    logic               w_tick;
    logic               w_grant_ev;
    logic               w_rel_ev;
    logic               w_to_ev;

    logic [2:0]         w_grant_nxt;
    logic [3:0]         w_sel_nxt;
    logic [3:0]         w_cmd_nxt;
    logic               w_busy_nxt;
    logic               w_to_nxt;

    assign w_elig        = req_i & ~r_lockout;
    assign w_pick        = prio_pick(w_elig);
    assign w_own_req     = |(req_i & grant_o);
    assign w_own_st      = (r_state == ST_OWN);
    assign w_timeout_hit = (r_hold != '0) && (r_ms_cnt == r_hold);

    always_comb begin
        w_pick_sel = req_sel_i[2:0];
        w_pick_cmd = req_cmd_i[3:0];
        case (w_pick)
            REQ_TIME: begin
                w_pick_sel = req_sel_i[5:3];
                w_pick_cmd = req_cmd_i[7:4];
            end
            REQ_CAL: begin
                w_pick_sel = req_sel_i[8:6];
                w_pick_cmd = req_cmd_i[11:8];
            end
            default: begin
                w_pick_sel = req_sel_i[2:0];
                w_pick_cmd = req_cmd_i[3:0];
            end
        endcase
    end

    ms_tick_gen #(.UNIT_MS(UNIT_MS)) u_ms_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_own_st),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A dropped request on the timeout edge wins: it is a plain release.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ev  = 1'b0;
        w_rel_ev    = 1'b0;
        w_to_ev     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_grant_ev  = 1'b1;
                    w_state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!w_own_req) begin
                    w_rel_ev    = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (w_timeout_hit) begin
                    w_to_ev     = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = grant_o;
        w_sel_nxt   = 4'd0;
        w_cmd_nxt   = pmt_scan_cmd_o;
        w_to_nxt    = 1'b0;
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        if (w_grant_ev) begin
            w_grant_nxt = 3'b001 << w_pick;
            w_sel_nxt   = sel_strobe(acc_job_control_i, w_pick_sel);
            w_cmd_nxt   = w_pick_cmd;
        end else if (w_rel_ev || w_to_ev) begin
            w_grant_nxt = 3'd0;
            w_sel_nxt   = r_sel_lat;
            w_cmd_nxt   = 4'd0;
            w_to_nxt    = w_to_ev;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_o            <= '0;
            busy_o             <= 1'b0;
            timeout_o          <= 1'b0;
            pmt_scan_cmd_sel_o <= '0;
            pmt_scan_cmd_o     <= '0;
        end else begin
            grant_o            <= w_grant_nxt;
            busy_o             <= w_busy_nxt;
            timeout_o          <= w_to_nxt;
            pmt_scan_cmd_sel_o <= w_sel_nxt;
            pmt_scan_cmd_o     <= w_cmd_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lockout <= '0;
            r_sel_lat <= '0;
            r_hold    <= '0;
            r_ms_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_lockout <= (r_lockout | ({3{w_to_ev}} & grant_o)) & req_i;
            if (w_grant_ev) begin
                r_sel_lat <= sel_strobe(acc_job_control_i, w_pick_sel);
                r_hold    <= hold_ms_i;
            end
            if (w_state_nxt != ST_OWN || w_grant_ev)
                r_ms_cnt <= '0;
            else if (w_tick && r_ms_cnt != 32'hFFFF_FFFF)
                r_ms_cnt <= r_ms_cnt + 32'd1;
            if (w_rel_ev || w_to_ev)
                r_gap_cnt <= GAP_LOAD;
            else if (r_state == ST_GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_pmt_scan_arb.sv
// Bench for pmt_scan_arb: timestamp-based reference model feeds an event
// scoreboard; a negedge monitor compares strobes, grants and timeouts.
module tb_pmt_scan_arb;
    import pmt_scan_pkg::*;

    localparam int UNIT = 10;
    localparam int GAP  = 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        acc  = 1'b0;
    logic [2:0]  req  = '0;
    logic [8:0]  rsel = '0;
    logic [11:0] rcmd = '0;
    logic [31:0] hold = '0;
    logic [2:0]  grant;
    logic        busy;
    logic        to_o;
    logic [3:0]  sel_o;
    logic [3:0]  cmd_o;

    pmt_scan_arb #(.TCQ(0.1), .UNIT_MS(UNIT), .GAP_CYC(GAP)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .acc_job_control_i  (acc),
        .req_i              (req),
        .req_sel_i          (rsel),
        .req_cmd_i          (rcmd),
        .hold_ms_i          (hold),
        .grant_o            (grant),
        .busy_o             (busy),
        .timeout_o          (to_o),
        .pmt_scan_cmd_sel_o (sel_o),
        .pmt_scan_cmd_o     (cmd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] grant;
        logic [3:0] sel;
        logic [3:0] cmd;
        logic       to;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;

    // Reference model state, expressed as timestamps rather than counters.
    int          m_owner     = -1;
    int          m_gcyc      = 0;
    longint      m_hold      = 0;
    logic [3:0]  m_sel4      = '0;
    logic [3:0]  m_cmd       = '0;
    logic [2:0]  m_lock      = '0;
    int          m_idle_from = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int n, input logic [2:0] s, input logic [3:0] c);
        rsel[3*n +: 3] = s;
        rcmd[4*n +: 4] = c;
    endtask

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] elig;
        logic [2:0] lset;
        int         n;
        ev_t        e;
        if (rst) begin
            m_owner     = -1;
            m_cmd       = '0;
            m_lock      = '0;
            m_idle_from = 0;
        end else begin
            cyc++;
            elig = req & ~m_lock;
            lset = '0;
            if (m_owner >= 0) begin
                if (!req[m_owner] ||
                    (m_hold != 0 && longint'(cyc - m_gcyc) == m_hold * UNIT + 1)) begin
                    e.cyc   = cyc;
                    e.grant = '0;
                    e.sel   = m_sel4;
                    e.cmd   = '0;
                    e.to    = req[m_owner];
                    exp_q.push_back(e);
                    if (req[m_owner])
                        lset[m_owner] = 1'b1;
                    m_owner     = -1;
                    m_cmd       = '0;
                    m_idle_from = cyc + GAP + 1;
                end
            end else if (cyc >= m_idle_from && elig != 0) begin
                n       = elig[0] ? 0 : (elig[1] ? 1 : 2);
                m_owner = n;
                m_gcyc  = cyc;
                m_hold  = longint'(hold);
                m_sel4  = {acc & (|rsel[3*n +: 3]), rsel[3*n +: 3]};
                m_cmd   = rcmd[4*n +: 4];
                e.cyc   = cyc;
                e.grant = 3'(1 << n);
                e.sel   = m_sel4;
                e.cmd   = m_cmd;
                e.to    = 1'b0;
                exp_q.push_back(e);
            end
            m_lock = (m_lock | lset) & req;
        end
    end

    logic [2:0] prev_grant = '0;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            check("busy", {31'd0, busy}, {31'd0, (m_owner >= 0) || (cyc < m_idle_from - 1)});
            check("cmd_hold", {28'd0, cmd_o}, {28'd0, m_cmd});
            if (sel_o != 0 || to_o || grant != prev_grant) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event @cyc %0d: actual grant=%b sel=%b to=%b required no event",
                             cyc, grant, sel_o, to_o);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_grant", {29'd0, grant}, {29'd0, e.grant});
                    check("ev_sel", {28'd0, sel_o}, {28'd0, e.sel});
                    check("ev_cmd", {28'd0, cmd_o}, {28'd0, e.cmd});
                    check("ev_timeout", {31'd0, to_o}, {31'd0, e.to});
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_event @cyc %0d: actual none required grant=%b sel=%b to=%b",
                         cyc, e.grant, e.sel, e.to);
            end
            prev_grant = grant;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual time limit hit required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b;
        int g;
        repeat (3) @(negedge clk);
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout", {31'd0, to_o}, 32'd0);
        check("rst_sel", {28'd0, sel_o}, 32'd0);
        check("rst_cmd", {28'd0, cmd_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single real-scan transaction with accumulate flag.
        set_req(0, 3'b101, 4'(1 << CMD_START_BIT));
        acc  = 1'b1;
        hold = 0;
        req  = 3'b001;
        @(negedge clk);
        check("r031_grant", {29'd0, grant}, 32'b001);
        check("r031_sel", {28'd0, sel_o}, 32'b1101);
        check("r031_cmd", {28'd0, cmd_o}, 32'h1);
        @(negedge clk);
        check("r031_sel_pulse", {28'd0, sel_o}, 32'd0);
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        check("r031_rel_sel", {28'd0, sel_o}, 32'b1101);
        check("r031_rel_cmd", {28'd0, cmd_o}, 32'd0);
        b = busy ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (busy) b++;
        end
        check("r031_busy_cycles", b, GAP);

        // Priority and non-preemption.
        set_req(1, 3'b010, 4'(1 << CMD_TEST_BIT));
        set_req(2, 3'b011, 4'h3);
        req = 3'b110;
        @(negedge clk);
        check("r032_grant", {29'd0, grant}, 32'b010);
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("r032_no_preempt", {29'd0, grant}, 32'b010);
        req[1] = 1'b0;
        w = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (grant == 3'b001) begin
                w = i;
                break;
            end
        end
        check("r032_wait", w, GAP + 2);
        req = 3'b000;
        repeat (8) @(negedge clk);

        // Timeout, lockout, regrant after drop.
        hold = 3;
        req  = 3'b100;
        @(negedge clk);
        check("r033_grant", {29'd0, grant}, 32'b100);
        w = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (to_o) begin
                w = i;
                break;
            end
        end
        check("r033_timeout_at", w, 3 * UNIT + 1);
        repeat (20) @(negedge clk);
        check("r033_locked", {29'd0, grant}, 32'd0);
        req = 3'b000;
        @(negedge clk);
        req = 3'b100;
        @(negedge clk);
        check("r033_regrant", {29'd0, grant}, 32'b100);
        req = 3'b000;
        repeat (8) @(negedge clk);

        // Drop on the exact timeout edge counts as a release.
        hold = 2;
        req  = 3'b100;
        @(negedge clk);
        g = cyc;
        repeat (2 * UNIT) @(negedge clk);
        check("r034_drop_cycle", cyc - g, 2 * UNIT);
        req = 3'b000;
        @(negedge clk);
        check("r034_no_timeout", {31'd0, to_o}, 32'd0);
        check("r034_released", {29'd0, grant}, 32'd0);
        req = 3'b100;
        w = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (grant == 3'b100) begin
                w = i;
                break;
            end
        end
        check("r034_regrant_wait", w, GAP + 1);
        req = 3'b000;
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-ownership.
        hold = 0;
        req  = 3'b001;
        repeat (4) @(negedge clk);
        check("r035_owned", {29'd0, grant}, 32'b001);
        #2 rst = 1'b1;
        #1;
        check("r035_cmd_async", {28'd0, cmd_o}, 32'd0);
        check("r035_grant_async", {29'd0, grant}, 32'd0);
        check("r035_no_strobe", {28'd0, sel_o}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("r035_regrant", {29'd0, grant}, 32'b001);
        req = 3'b000;
        repeat (8) @(negedge clk);

        // Randomized traffic; sel/cmd/hold churn freely during ownership.
        repeat (3000) begin
            @(negedge clk);
            acc  = 1'($urandom_range(0, 1));
            hold = 32'($urandom_range(0, 3));
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(n, 3'($urandom_range(1, 7)), 4'($urandom));
                if (!req[n] && $urandom_range(0, 5) == 0)
                    req[n] = 1'b1;
                else if (req[n] && $urandom_range(0, 19) == 0)
                    req[n] = 1'b0;
            end
        end

        req = 3'b000;
        repeat (30) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
